// File: rtl/pwm_multi_ch_pkg.sv
// Register map constants and CTRL field positions for the multi-channel PWM.
package pwm_multi_ch_pkg;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_PERIOD = 8'h04;
    localparam logic [7:0] REG_STATUS = 8'h08;
    localparam logic [7:0] REG_POL    = 8'h0C;
    localparam logic [7:0] REG_DUTY0  = 8'h10;

    localparam int unsigned CTRL_EN_BIT    = 0;
    localparam int unsigned CTRL_PRESC_LSB = 8;
    localparam int unsigned CTRL_PRESC_W   = 8;

    // Word index of a byte offset; the bus decodes address bits [7:2] only.
    function automatic logic [5:0] word_idx(input logic [7:0] off);
        return off[7:2];
    endfunction

endpackage

// File: rtl/pwm_multi_ch_ch.sv
// One PWM channel: double-buffered duty register, compare against the shared
// counter, registered output with optional inversion.
module pwm_ch
    import pwm_multi_ch_pkg::*;
#(
    parameter int unsigned      CNT_W      = 12,
    parameter logic [CNT_W-1:0] RESET_DUTY = 'h800
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [CNT_W-1:0] wdata_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic             pol_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic [CNT_W-1:0] duty_o,
    output logic             pwm_o
);

    logic [CNT_W-1:0] duty_sh_q;
    logic [CNT_W-1:0] duty_act_q;
    logic             pwm_q;
    logic             pwm_d;

    // Compare result gated by enable, then inverted when polarity is set.
    always_comb begin
        pwm_d = (en_i & (cnt_i < duty_act_q)) ^ pol_i;
    end

    // Shadow written by the bus; active copy only follows it on load.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            duty_sh_q  <= RESET_DUTY;
            duty_act_q <= RESET_DUTY;
            pwm_q      <= 1'b0;
        end else begin
            if (we_i)   duty_sh_q  <= wdata_i;
            if (load_i) duty_act_q <= duty_sh_q;
            pwm_q <= pwm_d;
        end
    end

    assign duty_o = duty_sh_q;
    assign pwm_o  = pwm_q;

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel bus-mapped PWM: shared prescaler and period counter, one
// duty register per channel. Optional polarity register: PWM_POLARITY_EN.
module pwm_multi_ch
    import pwm_multi_ch_pkg::*;
#(
    parameter int unsigned      NUM_CH     = 4,
    parameter int unsigned      CNT_W      = 12,
    parameter logic [CNT_W-1:0] RESET_DUTY = 'h800,
    parameter logic [CNT_W-1:0] RESET_PER  = 'hFFF
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [31:0]       iADR,
    input  logic [31:0]       iDAT,
    input  logic              iWE,
    input  logic              iSTB,
    output logic              oACK,
    output logic [31:0]       oDAT,
    output logic [NUM_CH-1:0] oPWM
);

    logic              ack_q;
    logic [31:0]       dat_q;
    logic              en_q;
    logic [7:0]        presc_q;
    logic [7:0]        psc_cnt_q, psc_cnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  period_sh_q, period_act_q;
    logic              wrap_flag_q;
    logic [31:0]       rdata;
    logic [NUM_CH-1:0] pol;
    logic [NUM_CH-1:0] pwm;
    logic [CNT_W-1:0]  duty_rd [NUM_CH];

    logic [5:0] widx;
    logic       access, wr, tick, wrap, load;
    logic       sel_ctrl, sel_period, sel_status;
    logic       unused_bits;

    assign widx       = iADR[7:2];
    assign access     = iSTB & ~ack_q;
    assign wr         = access & iWE;
    assign sel_ctrl   = (widx == word_idx(REG_CTRL));
    assign sel_period = (widx == word_idx(REG_PERIOD));
    assign sel_status = (widx == word_idx(REG_STATUS));
    assign tick       = en_q & (psc_cnt_q == presc_q);
    assign wrap       = tick & (cnt_q == period_act_q);
    assign load       = wrap | ~en_q;
    assign unused_bits = ^{iADR[31:8], iADR[1:0], iDAT[31:16]};

`ifdef PWM_POLARITY_EN
    logic [NUM_CH-1:0] pol_q;

    // Polarity register; applies to the next output sample, no wrap sync.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            pol_q <= '0;
        end else if (wr && widx == word_idx(REG_POL)) begin
            pol_q <= iDAT[NUM_CH-1:0];
        end
    end
    assign pol = pol_q;
`else
    assign pol = '0;
`endif

    // Read mux; unmapped offsets and unused upper bits return zero.
    always_comb begin
        rdata = '0;
        if (sel_ctrl) begin
            rdata[CTRL_EN_BIT] = en_q;
            rdata[CTRL_PRESC_LSB +: CTRL_PRESC_W] = presc_q;
        end else if (sel_period) begin
            rdata = 32'(period_sh_q);
        end else if (sel_status) begin
            rdata[0] = wrap_flag_q;
        end
`ifdef PWM_POLARITY_EN
        else if (widx == word_idx(REG_POL)) begin
            rdata = 32'(pol);
        end
`endif
        for (int n = 0; n < NUM_CH; n++) begin
            if (widx == word_idx(REG_DUTY0) + 6'(n)) rdata = 32'(duty_rd[n]);
        end
    end

    // Bus handshake, CTRL/PERIOD/STATUS registers and active period copy.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            ack_q        <= 1'b0;
            dat_q        <= '0;
            en_q         <= 1'b0;
            presc_q      <= '0;
            period_sh_q  <= RESET_PER;
            period_act_q <= RESET_PER;
            wrap_flag_q  <= 1'b0;
        end else begin
            ack_q <= access;
            if (access) dat_q <= rdata;
            if (wr && sel_ctrl) begin
                en_q    <= iDAT[CTRL_EN_BIT];
                presc_q <= iDAT[CTRL_PRESC_LSB +: CTRL_PRESC_W];
            end
            if (wr && sel_period) period_sh_q <= iDAT[CNT_W-1:0];
            if (load) period_act_q <= period_sh_q;
            // Set wins over a simultaneous write-one-to-clear.
            wrap_flag_q <= wrap | (wrap_flag_q & ~(wr & sel_status & iDAT[0]));
        end
    end

    // Next state of prescaler and shared period counter.
    always_comb begin
        psc_cnt_d = psc_cnt_q;
        cnt_d     = cnt_q;
        if (!en_q) begin
            psc_cnt_d = '0;
            cnt_d     = '0;
        end else if (tick) begin
            psc_cnt_d = '0;
            cnt_d     = wrap ? '0 : cnt_q + CNT_W'(1);
        end else begin
            psc_cnt_d = psc_cnt_q + 8'd1;
        end
    end

    // Timebase registers.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            psc_cnt_q <= '0;
            cnt_q     <= '0;
        end else begin
            psc_cnt_q <= psc_cnt_d;
            cnt_q     <= cnt_d;
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        pwm_ch #(
            .CNT_W      (CNT_W),
            .RESET_DUTY (RESET_DUTY)
        ) u_ch (
            .clk_i   (iCLK),
            .rst_ni  (iRST),
            .we_i    (wr && (widx == word_idx(REG_DUTY0) + 6'(n))),
            .wdata_i (iDAT[CNT_W-1:0]),
            .load_i  (load),
            .en_i    (en_q),
            .pol_i   (pol[n]),
            .cnt_i   (cnt_q),
            .duty_o  (duty_rd[n]),
            .pwm_o   (pwm[n])
        );
    end

    assign oACK = ack_q;
    assign oDAT = dat_q;
    assign oPWM = pwm;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Self-checking bench for pwm_multi_ch: register readback via a scoreboard
// queue, PWM duty measured by sample counting and pulse-width monitoring.
module tb_pwm_multi_ch;
    import pwm_multi_ch_pkg::*;

    localparam int NCH = 4;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b0;
    logic [31:0] iADR = '0;
    logic [31:0] iDAT = '0;
    logic        iWE  = 1'b0;
    logic        iSTB = 1'b0;
    logic        oACK;
    logic [31:0] oDAT;
    logic [NCH-1:0] oPWM;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q [$];
    int pulses [$];
    int run = 0;
    int mon_ch = 1;
    int hi [NCH];

    pwm_multi_ch #(.NUM_CH(NCH), .CNT_W(12)) dut (
        .iCLK(iCLK), .iRST(iRST), .iADR(iADR), .iDAT(iDAT),
        .iWE(iWE), .iSTB(iSTB), .oACK(oACK), .oDAT(oDAT), .oPWM(oPWM)
    );

    always #5 iCLK = ~iCLK;

    // High-pulse width monitor for the selected channel.
    always @(negedge iCLK) begin
        if (oPWM[mon_ch]) run = run + 1;
        else if (run != 0) begin
            pulses.push_back(run);
            run = 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Single write; caller must not be sitting exactly on a rising edge.
    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        iADR = 32'(a); iDAT = d; iWE = 1'b1; iSTB = 1'b1;
        @(posedge iCLK); #1;
        iSTB = 1'b0; iWE = 1'b0;
        @(posedge iCLK); #1;
    endtask

    // Single read; expected value queued at issue, compared when ack arrives.
    task automatic bus_rd(input string tag, input logic [7:0] a, input logic [31:0] e);
        logic [31:0] ex;
        exp_q.push_back(e);
        iADR = 32'(a); iWE = 1'b0; iSTB = 1'b1;
        @(posedge iCLK); #1;
        iSTB = 1'b0;
        check_eq({tag, "_ack"}, 32'(oACK), 32'd1);
        ex = exp_q.pop_front();
        check_eq(tag, oDAT, ex);
        @(posedge iCLK); #1;
    endtask

    task automatic measure(input int n);
        for (int c = 0; c < NCH; c++) hi[c] = 0;
        repeat (n) begin
            @(negedge iCLK);
            for (int c = 0; c < NCH; c++) hi[c] += int'(oPWM[c]);
        end
    endtask

    task automatic wait_pulses(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && pulses.size() < n; i++) @(negedge iCLK);
        check_eq({tag, "_cnt"}, 32'(pulses.size() >= n), 32'd1);
    endtask

    initial begin
        int acks;
        logic prev;
        int w1, w2;

        // Reset values
        repeat (3) @(negedge iCLK);
        check_eq("rst_ack", 32'(oACK), 0);
        check_eq("rst_dat", oDAT, 0);
        check_eq("rst_pwm", 32'(oPWM), 0);
        iRST = 1'b1;
        @(negedge iCLK);
        bus_rd("rst_duty0", REG_DUTY0, 32'h800);
        bus_rd("rst_period", REG_PERIOD, 32'hFFF);
        bus_rd("rst_ctrl", REG_CTRL, 32'h0);

        // Basic duty patterns, PRESC=0, PERIOD=9
        bus_wr(REG_PERIOD, 9);
        bus_wr(REG_DUTY0 + 8'h0, 0);
        bus_wr(REG_DUTY0 + 8'h4, 3);
        bus_wr(REG_DUTY0 + 8'h8, 10);
        bus_wr(REG_DUTY0 + 8'hC, 5);
        bus_wr(REG_CTRL, 32'h1);
        repeat (5) @(negedge iCLK);
        measure(20);
        check_eq("t2_ch0", 32'(hi[0]), 0);
        check_eq("t2_ch1", 32'(hi[1]), 6);
        check_eq("t2_ch2", 32'(hi[2]), 20);
        check_eq("t2_ch3", 32'(hi[3]), 10);
        #1;
        bus_rd("t2_status", REG_STATUS, 32'h1);
        bus_rd("t2_duty1", REG_DUTY0 + 8'h4, 32'h3);
        bus_rd("t2_ctrl", REG_CTRL, 32'h1);

        // Mid-period duty write keeps the current pulse width
        @(negedge iCLK);
        prev = oPWM[1];
        for (int i = 0; i < 40; i++) begin
            @(negedge iCLK);
            if (oPWM[1] && !prev) break;
            prev = oPWM[1];
        end
        check_eq("t3_rise", 32'(oPWM[1]), 1);
        pulses.delete();
        bus_wr(REG_DUTY0 + 8'h4, 7);
        wait_pulses("t3", 2, 60);
        w1 = (pulses.size() > 0) ? pulses[0] : -1;
        w2 = (pulses.size() > 1) ? pulses[1] : -1;
        check_eq("t3_cur", 32'(w1), 3);
        check_eq("t3_next", 32'(w2), 7);

        // Prescaler: PRESC=3 gives a 40-clock period, 20 high
        mon_ch = 0;
        bus_wr(REG_CTRL, 32'h0301);
        bus_wr(REG_DUTY0, 5);
        repeat (100) @(negedge iCLK);
        measure(80);
        check_eq("t4_ch0_hi", 32'(hi[0]), 40);
        check_eq("t4_ch1_hi", 32'(hi[1]), 56);
        #1 pulses.delete();
        wait_pulses("t4", 2, 120);
        w1 = (pulses.size() > 0) ? pulses[0] : -1;
        check_eq("t4_width", 32'(w1), 20);
        #1;
        bus_wr(REG_CTRL, 32'h0300);
        @(negedge iCLK);
        @(negedge iCLK);
        check_eq("t4_en_off", 32'(oPWM), 0);
        #1;
        bus_rd("t4_ctrl", REG_CTRL, 32'h300);
        bus_rd("t4_status_set", REG_STATUS, 32'h1);
        bus_wr(REG_STATUS, 32'h1);
        bus_rd("t4_status_clr", REG_STATUS, 32'h0);

        // Polarity
        bus_wr(REG_DUTY0, 3);
        bus_wr(REG_POL, 32'h1);
        bus_wr(REG_CTRL, 32'h1);
        repeat (20) @(negedge iCLK);
        measure(20);
        #1;
`ifdef PWM_POLARITY_EN
        check_eq("t6_ch0_inv", 32'(hi[0]), 14);
        bus_rd("t6_pol", REG_POL, 32'h1);
        bus_wr(REG_CTRL, 32'h0);
        @(negedge iCLK);
        @(negedge iCLK);
        check_eq("t6_en0_pol", 32'(oPWM), 32'h1);
        #1;
        bus_wr(REG_POL, 32'h0);
        bus_wr(REG_CTRL, 32'h1);
`else
        check_eq("t6_ch0", 32'(hi[0]), 6);
        bus_rd("t6_pol", REG_POL, 32'h0);
`endif

        // PERIOD=0: counter pinned, outputs follow DUTY!=0
        bus_wr(REG_DUTY0, 0);
        bus_wr(REG_PERIOD, 0);
        repeat (30) @(negedge iCLK);
        for (int i = 0; i < 3; i++) begin
            check_eq("p0_pwm", 32'(oPWM), 32'hE);
            repeat (3) @(negedge iCLK);
        end
        #1;
        bus_rd("p0_period", REG_PERIOD, 32'h0);

        // Bus corner cases
        bus_rd("t5_unmap", 8'h20, 32'h0);
        bus_wr(8'h20, 32'hFFFF);
        bus_rd("t5_unmap_wr", 8'h20, 32'h0);
        iADR = 32'(REG_PERIOD); iWE = 1'b0; iSTB = 1'b1;
        acks = 0;
        repeat (4) begin
            @(posedge iCLK); #1;
            acks += int'(oACK);
        end
        iSTB = 1'b0;
        check_eq("t5_held_acks", 32'(acks), 2);
        @(posedge iCLK); #1;
        iADR = 32'(REG_PERIOD); iDAT = 32'h55; iWE = 1'b0; iSTB = 1'b1;
        @(posedge iCLK); #1;
        iSTB = 1'b0;
        @(posedge iCLK); #1;
        bus_rd("t5_we0", REG_PERIOD, 32'h0);

        // Asynchronous reset while running
        @(negedge iCLK);
        check_eq("t1_pre_pwm", 32'(oPWM), 32'hE);
        #2 iRST = 1'b0;
        #1;
        check_eq("t1_async_pwm", 32'(oPWM), 0);
        check_eq("t1_async_ack", 32'(oACK), 0);
        @(negedge iCLK);
        iRST = 1'b1;
        #1;
        bus_rd("t1_duty0", REG_DUTY0, 32'h800);
        bus_rd("t1_duty3", REG_DUTY0 + 8'hC, 32'h800);
        bus_rd("t1_period", REG_PERIOD, 32'hFFF);
        bus_rd("t1_ctrl", REG_CTRL, 32'h0);
        bus_rd("t1_status", REG_STATUS, 32'h0);
        check_eq("t1_pwm", 32'(oPWM), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
